// File: rtl/tanh_vec_ctrl.sv
// Streams a vector from a source buffer through one Tanh unit and writes each result back at the same index.
// Latency: 8 cycles per element with a 4-state Tanh unit; done arrives 8*len+1 cycles after the accepted start.
// Backpressure: waits on rdy_t in REQ/WAIT for at most TMO cycles, then aborts to ERR with a sticky err flag.
module tanh_vec_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 6,
    parameter int N_MAX = 64,
    parameter int TMO   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          cs_tanh,
    output logic [DW-1:0] th,
    input  logic          rdy_t,
    input  logic [DW-1:0] z,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    localparam int            TW    = $clog2(TMO + 1);
    localparam logic [AW:0]   L_MAX = (AW+1)'(N_MAX);
    localparam logic [AW:0]   L_ONE = (AW+1)'(1);
    localparam logic [TW-1:0] T_END = TW'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_REQ, S_WAIT, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic          w_last;
    logic [AW-1:0] w_idx_next;
    logic [AW:0]   w_len_clamp;

    logic [AW:0]   r_len;
    logic [AW-1:0] r_idx;
    logic [TW-1:0] r_tmo;
    logic          r_busy, r_done, r_err, r_rd_en, r_cs, r_wr_en;
    logic [AW-1:0] r_rd_addr, r_wr_addr;
    logic [DW-1:0] r_th, r_wr_data;

    assign w_last      = ({1'b0, r_idx} == (r_len - L_ONE));
    assign w_len_clamp = (len > L_MAX) ? L_MAX : len;

    // Next-state and index selection; the timeout only fires if the awaited rdy_t level never showed up
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_idx_next = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept   = 1'b1;
                    w_idx_next = '0;
                    w_next     = (len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_REQ;
            S_REQ: begin
                if (!rdy_t)              w_next = S_WAIT;
                else if (r_tmo == T_END) w_next = S_ERR;
            end
            S_WAIT: begin
                if (rdy_t)               w_next = S_WRITE;
                else if (r_tmo == T_END) w_next = S_ERR;
            end
            S_WRITE: begin
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next     = S_FETCH;
                    w_idx_next = r_idx + AW'(1);
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Handshake wait counter, restarted on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        r_tmo <= '0;
        else if (w_next != r_state)                      r_tmo <= '0;
        else if (r_state == S_REQ || r_state == S_WAIT)  r_tmo <= r_tmo + TW'(1);
    end

    // Registered outputs are decoded from the next state so they line up with the state they belong to
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len     <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_cs      <= 1'b0;
            r_th      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_idx   <= w_idx_next;
            r_busy  <= w_next inside {S_FETCH, S_LOAD, S_REQ, S_WAIT, S_WRITE};
            r_done  <= (w_next == S_DONE);
            r_rd_en <= (w_next == S_FETCH);
            r_cs    <= (w_next == S_REQ);
            r_wr_en <= (w_next == S_WRITE);
            if (w_accept)               r_len     <= w_len_clamp;
            if (w_accept)               r_err     <= 1'b0;
            else if (w_next == S_ERR)   r_err     <= 1'b1;
            if (w_next == S_FETCH)      r_rd_addr <= w_idx_next;
            if (w_next == S_WRITE)      r_wr_addr <= r_idx;
            if (r_state == S_LOAD)      r_th      <= rd_data;
            if (r_state == S_WAIT && rdy_t) r_wr_data <= z;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign cs_tanh = r_cs;
    assign th      = r_th;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_tanh_vec_ctrl.sv
// Bench for tanh_vec_ctrl: source/destination buffer models, a 4-state Tanh unit model, and a
// result reference built from the vector rules (min(len,N_MAX) writes, 8 cycles per element).
module tb_tanh_vec_ctrl;
    localparam int DW = 16, AW = 6, N_MAX = 64, TMO = 255;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [AW:0]   len;
    logic          busy, done, err, rd_en, cs_tanh, wr_en, rdy_t;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data, th, z, wr_data;

    always #5 clk = ~clk;

    tanh_vec_ctrl #(.DW(DW), .AW(AW), .N_MAX(N_MAX), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .cs_tanh(cs_tanh), .th(th),
        .rdy_t(rdy_t), .z(z), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    logic [DW-1:0] src [64];
    logic [DW-1:0] dst [64];
    int            errors = 0, checks = 0;
    int            wr_cnt = 0, done_cnt = 0, rd_cnt = 0, cs_cnt = 0;
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];
    bit            stuck = 1'b0;
    int            t_st;
    logic [DW-1:0] t_op;

    // Tanh transfer: the four known points, anything else gets an arbitrary stand-in response
    function automatic logic [DW-1:0] tanh_ref(input logic [DW-1:0] x);
        case (x)
            16'h0800: return 16'h0800;
            16'h1500: return 16'h0E64;
            16'h0D00: return 16'h0B2A;
            16'h9500: return 16'h8E64;
            default:  return x ^ 16'h5A5A;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source buffer: one-cycle read latency
    always @(posedge clk or negedge rst)
        if (!rst)       rd_data <= '0;
        else if (rd_en) rd_data <= src[rd_addr];

    // Tanh unit: idle with rdy_t=1, takes cs_tanh, busy for 3 states, returns with rdy_t=1 and z valid
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_st <= 0; rdy_t <= 1'b1; z <= '0; t_op <= '0;
        end else begin
            case (t_st)
                0: if (cs_tanh && !stuck) begin t_st <= 1; rdy_t <= 1'b0; t_op <= th; end
                1: t_st <= 2;
                2: t_st <= 3;
                default: begin t_st <= 0; rdy_t <= 1'b1; z <= tanh_ref(t_op); end
            endcase
        end
    end

    // Activity monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                wr_cnt++;
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
                dst[wr_addr] = wr_data;
            end
            if (done)    done_cnt++;
            if (rd_en)   rd_cnt++;
            if (cs_tanh) cs_cnt++;
        end
    end

    task automatic fill_src();
        for (int i = 0; i < 64; i++) src[i] = 16'($urandom);
    endtask

    // Launch a vector; lat is the cycle (after the accepting edge) in which done is seen, -1 if never
    task automatic run(input int n, input bit hold, output int lat);
        @(negedge clk);
        start = 1'b1;
        len   = n[AW:0];
        lat   = -1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done) begin lat = cyc; break; end
            if (err) break;
        end
        start = 1'b0;
    endtask

    task automatic verify(input string tag, input int n_eff, input int wr0, input int dn0);
        check({tag, "_writes"}, wr_cnt - wr0, n_eff);
        check({tag, "_dones"}, done_cnt - dn0, 1);
        for (int i = 0; i < n_eff && (wr0 + i) < wa_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[wr0 + i]), i);
            check($sformatf("%s_data%0d", tag, i), 32'(wd_q[wr0 + i]), 32'(tanh_ref(src[i])));
        end
    endtask

    initial begin
        int lat, wr0, dn0, rd0, cs0, n;
        logic [DW-1:0] exp4 [4];
        exp4 = '{16'h0800, 16'h0E64, 16'h0B2A, 16'h8E64};
        rst = 1'b0; start = 1'b0; len = '0;
        #12;
        check("reset_ctrl", 32'({busy, done, err, rd_en, rd_addr, cs_tanh, wr_en, wr_addr}), 0);
        check("reset_data", {th, wr_data}, 0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vector through the Tanh unit
        src[0] = 16'h0800; src[1] = 16'h1500; src[2] = 16'h0D00; src[3] = 16'h9500;
        wr0 = wr_cnt; dn0 = done_cnt;
        run(4, 1'b0, lat);
        check("dir_latency", lat, 33);
        check("dir_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("dir_dst%0d", i), 32'(dst[i]), 32'(exp4[i]));
        verify("dir", 4, wr0, dn0);

        // Empty vector
        wr0 = wr_cnt; dn0 = done_cnt; rd0 = rd_cnt; cs0 = cs_cnt;
        run(0, 1'b0, lat);
        check("len0_latency", lat, 1);
        repeat (3) @(negedge clk);
        check("len0_rd", rd_cnt - rd0, 0);
        check("len0_cs", cs_cnt - cs0, 0);
        check("len0_wr", wr_cnt - wr0, 0);
        check("len0_done", done_cnt - dn0, 1);

        // Unit stuck with rdy_t=1: REQ times out
        stuck = 1'b1; fill_src();
        wr0 = wr_cnt; dn0 = done_cnt; lat = -1;
        @(negedge clk); start = 1'b1; len = 7'd3;
        for (int cyc = 1; cyc <= TMO + 20; cyc++) begin
            @(negedge clk); start = 1'b0;
            if (err) begin lat = cyc; break; end
        end
        check("tmo_latency", lat, TMO + 3);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_cs", 32'(cs_tanh), 0);
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", 32'(err), 1);
        check("tmo_wr", wr_cnt - wr0, 0);
        check("tmo_done", done_cnt - dn0, 0);
        stuck = 1'b0;
        wr0 = wr_cnt; dn0 = done_cnt;
        run(2, 1'b0, lat);
        check("tmo_recover_latency", lat, 17);
        check("tmo_err_cleared", 32'(err), 0);
        repeat (2) @(negedge clk);
        verify("tmo_recover", 2, wr0, dn0);

        // Reset while element 1 is waiting on the unit
        fill_src();
        wr0 = wr_cnt;
        @(negedge clk); start = 1'b1; len = 7'd4;
        @(negedge clk); start = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_reset_ctrl", 32'({busy, done, err, rd_en, rd_addr, cs_tanh, wr_en, wr_addr}), 0);
        check("mid_reset_data", {th, wr_data}, 0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_partial_wr", wr_cnt - wr0, 1);
        fill_src();
        wr0 = wr_cnt; dn0 = done_cnt;
        run(2, 1'b0, lat);
        check("mid_after_latency", lat, 17);
        repeat (3) @(negedge clk);
        verify("mid_after", 2, wr0, dn0);

        // start held high through a run is accepted once
        fill_src();
        wr0 = wr_cnt; dn0 = done_cnt;
        run(3, 1'b1, lat);
        check("hold_latency", lat, 25);
        repeat (10) @(negedge clk);
        verify("hold", 3, wr0, dn0);

        // Length above N_MAX is clamped
        fill_src();
        wr0 = wr_cnt; dn0 = done_cnt;
        run(100, 1'b0, lat);
        check("clamp_latency", lat, 8 * N_MAX + 1);
        repeat (3) @(negedge clk);
        verify("clamp", N_MAX, wr0, dn0);

        // Random vectors
        for (int r = 0; r < 6; r++) begin
            fill_src();
            n = int'($urandom_range(1, 20));
            wr0 = wr_cnt; dn0 = done_cnt;
            run(n, 1'b0, lat);
            check($sformatf("rnd%0d_latency", r), lat, 8 * n + 1);
            check($sformatf("rnd%0d_err", r), 32'(err), 0);
            repeat (2) @(negedge clk);
            verify($sformatf("rnd%0d", r), n, wr0, dn0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
